// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle Fetch/Decode/Execute/WriteBack sequencer for the 16-bit ALU datapath.
// Build macro ALU_SEQ_BRANCH_EN turns codop 13 (BZ) / 14 (BN) into PC-relative conditional branches.
module alu_seq_ctrl #(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'h0001,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [2:0]  fsm,
  output logic [3:0]  codop,
  output logic [3:0]  rd_addr,
  output logic [3:0]  rs_addr,
  output logic [3:0]  rt_addr,
  output logic [15:0] imm,
  output logic        use_imm,
  output logic        rf_we,
  input  logic        alu_neg,
  input  logic        alu_zero,
  input  logic        alu_ovf,
  output logic [2:0]  flags,
  output logic [15:0] pc,
  output logic        busy,
  output logic        halted,
  output logic        fetch_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WB     = 3'd1,
    S_FETCH  = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0]  OP_HALT   = 4'd12;
  localparam logic        WAIT_EN   = (MAX_WAIT != 32'd0);
  localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 32'd1);
`ifdef ALU_SEQ_BRANCH_EN
  localparam logic [3:0]  OP_BZ     = 4'd13;
  localparam logic [3:0]  OP_BN     = 4'd14;
`endif

  state_t      state_q;
  logic [15:0] pc_q;
  logic [15:0] pc_d;
  logic [15:0] ir_q;
  logic [15:0] wait_q;
  logic [2:0]  flags_q;
  logic        imem_req_q;
  logic        rf_we_q;
  logic        busy_q;
  logic        halted_q;
  logic        fetch_err_q;
  logic        use_imm_q;

  // Arithmetic/logic/immediate codops write the register file and update flags.
  function automatic logic writes_rf(input logic [3:0] op);
    return (op <= 4'd10);
  endfunction

  function automatic logic is_imm_op(input logic [3:0] op);
    return (op >= 4'd6) && (op <= 4'd10);
  endfunction

  // Next PC applied at the end of WriteBack.
  always_comb begin
    pc_d = pc_q + PC_STEP;
`ifdef ALU_SEQ_BRANCH_EN
    if (((ir_q[15:12] == OP_BZ) && flags_q[1]) || ((ir_q[15:12] == OP_BN) && flags_q[2])) begin
      pc_d = pc_q + {{12{ir_q[3]}}, ir_q[3:0]};
    end else begin
      pc_d = pc_q + PC_STEP;
    end
`endif
  end

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= PC_RESET;
      ir_q        <= 16'h0000;
      wait_q      <= 16'h0000;
      flags_q     <= 3'b000;
      imem_req_q  <= 1'b0;
      rf_we_q     <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      fetch_err_q <= 1'b0;
      use_imm_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_FETCH;
            imem_req_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            state_q    <= S_DECODE;
            imem_req_q <= 1'b0;
            ir_q       <= imem_data;
            use_imm_q  <= is_imm_op(imem_data[15:12]);
            wait_q     <= 16'h0000;
          end else if (WAIT_EN && (wait_q == WAIT_LAST)) begin
            state_q     <= S_HALT;
            imem_req_q  <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b1;
            fetch_err_q <= 1'b1;
            wait_q      <= 16'h0000;
          end else begin
            wait_q <= wait_q + 16'd1;
          end
        end
        S_DECODE: begin
          if (ir_q[15:12] == OP_HALT) begin
            state_q  <= S_HALT;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          state_q <= S_WB;
          rf_we_q <= writes_rf(ir_q[15:12]);
        end
        S_WB: begin
          state_q    <= S_FETCH;
          imem_req_q <= 1'b1;
          rf_we_q    <= 1'b0;
          pc_q       <= pc_d;
          if (writes_rf(ir_q[15:12])) begin
            flags_q <= {alu_neg, alu_zero, alu_ovf};
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q    <= S_IDLE;
          imem_req_q <= 1'b0;
          rf_we_q    <= 1'b0;
          busy_q     <= 1'b0;
          halted_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign fsm       = state_q;
  assign codop     = ir_q[15:12];
  assign rd_addr   = ir_q[11:8];
  assign rs_addr   = ir_q[7:4];
  assign rt_addr   = ir_q[3:0];
  assign imm       = {12'h000, ir_q[3:0]};
  assign use_imm   = use_imm_q;
  assign rf_we     = rf_we_q;
  assign flags     = flags_q;
  assign pc        = pc_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign fetch_err = fetch_err_q;

endmodule
